// File: rtl/nco_clkgen_pkg.sv
// Shared constants and helpers for the NCO clock generator.
// Optional build macro used by this design: NCO_SYNC_EN.
package nco_pkg;

    localparam int NCO_NUM_CH = 2;
    localparam int NCO_ACC_W  = 24;

    // Channel-select width; a single channel still needs a 1-bit field.
    function automatic int ch_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/nco_clkgen_if.sv
// Increment write port of the NCO clock generator.
// Handshake: wr_en is a one-cycle strobe with no ready; a write is taken on every
// rising clk edge where wr_en=1, and writes with wr_ch >= NUM_CH are dropped.
interface nco_clkgen_if #(
    parameter int NUM_CH = 2,
    parameter int ACC_W  = 24,
    parameter int CH_W   = 1
);
    logic              wr_en;
    logic [CH_W-1:0]   wr_ch;
    logic [ACC_W-1:0]  wr_inc;

    modport master (output wr_en, output wr_ch, output wr_inc);
    modport slave  (input  wr_en, input  wr_ch, input  wr_inc);
endinterface

// File: rtl/nco_clkgen_channel.sv
// One NCO channel: phase accumulator, shadow/active increment and wrap tick.
// Increment changes take effect only at a wrap so clk_out never produces a runt pulse.
module nco_channel #(
    parameter int ACC_W = 24
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             ld,
    input  logic [ACC_W-1:0] ld_val,
    input  logic             clr,
    output logic             clk_out,
    output logic             tick,
    output logic             pending
);

    logic [ACC_W-1:0] acc, acc_n;
    logic [ACC_W-1:0] inc_act, inc_act_n;
    logic [ACC_W-1:0] inc_shd, inc_shd_n;
    logic             pend, pend_n;
    logic             tick_r, tick_n;
    logic [ACC_W:0]   sum;
    logic             carry;

    assign sum   = {1'b0, acc} + {1'b0, inc_act};
    assign carry = sum[ACC_W];

    // inc_shd equals inc_act whenever pend is clear, so copying the shadow is always safe.
    always_comb begin
        acc_n     = acc;
        inc_act_n = inc_act;
        inc_shd_n = inc_shd;
        pend_n    = pend;
        tick_n    = 1'b0;
        if (!en) begin
            acc_n     = '0;
            inc_act_n = inc_shd;
            if (ld) begin
                inc_shd_n = ld_val;
                pend_n    = 1'b1;
            end else begin
                pend_n    = 1'b0;
            end
        end else if (clr) begin
            acc_n     = '0;
            inc_act_n = ld ? ld_val : inc_shd;
            inc_shd_n = ld ? ld_val : inc_shd;
            pend_n    = 1'b0;
        end else begin
            acc_n  = sum[ACC_W-1:0];
            tick_n = carry;
            if (carry) begin
                inc_act_n = ld ? ld_val : inc_shd;
                inc_shd_n = ld ? ld_val : inc_shd;
                pend_n    = 1'b0;
            end else if (ld) begin
                inc_shd_n = ld_val;
                pend_n    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc     <= '0;
            inc_act <= '0;
            inc_shd <= '0;
            pend    <= 1'b0;
            tick_r  <= 1'b0;
        end else begin
            acc     <= acc_n;
            inc_act <= inc_act_n;
            inc_shd <= inc_shd_n;
            pend    <= pend_n;
            tick_r  <= tick_n;
        end
    end

    assign clk_out = acc[ACC_W-1];
    assign tick    = tick_r;
    assign pending = pend;

endmodule

// File: rtl/nco_clkgen.sv
// Multi-channel phase-accumulator clock generator: f_out = f_clk * inc / 2^ACC_W.
// Define NCO_SYNC_EN to add sync_in, whose rising edge phase-aligns all enabled channels.
module nco_clkgen
    import nco_pkg::*;
#(
    parameter int NUM_CH = NCO_NUM_CH,
    parameter int ACC_W  = NCO_ACC_W,
    parameter int CH_W   = ch_width(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset_n,
`ifdef NCO_SYNC_EN
    input  logic              sync_in,
`endif
    input  logic [NUM_CH-1:0] ch_en,
    nco_clkgen_if.slave       wr,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] pending
);

    logic clr;

`ifdef NCO_SYNC_EN
    logic sync_d;
    logic clr_r;

    // Edge is detected on the registered copy; the clear lands one cycle later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_d <= 1'b0;
            clr_r  <= 1'b0;
        end else begin
            sync_d <= sync_in;
            clr_r  <= sync_in & ~sync_d;
        end
    end

    assign clr = clr_r;
`else
    assign clr = 1'b0;
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic ld;

        // Only encodings below NUM_CH can match, so out-of-range writes fall away.
        assign ld = wr.wr_en && (wr.wr_ch == CH_W'(i));

        nco_channel #(.ACC_W(ACC_W)) u_ch (
            .clk     (clk),
            .reset_n (reset_n),
            .en      (ch_en[i]),
            .ld      (ld),
            .ld_val  (wr.wr_inc),
            .clr     (clr),
            .clk_out (clk_out[i]),
            .tick    (tick[i]),
            .pending (pending[i])
        );
    end

endmodule

// File: tb/tb_nco_clkgen.sv
// Self-checking bench for nco_clkgen: phase-arithmetic reference model plus directed pins.
module tb_nco_clkgen;
  import nco_pkg::*;

  localparam int NUM_CH = 3;
  localparam int ACC_W  = 10;
  localparam int CH_W   = 2;
  localparam int MOD    = 1 << ACC_W;
  localparam int HALF   = MOD / 2;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic [NUM_CH-1:0] ch_en = '0;
  logic [NUM_CH-1:0] clk_out, tick, pending;
`ifdef NCO_SYNC_EN
  logic sync_in = 1'b0;
`endif

  nco_clkgen_if #(.NUM_CH(NUM_CH), .ACC_W(ACC_W), .CH_W(CH_W)) wr_if ();

  nco_clkgen #(.NUM_CH(NUM_CH), .ACC_W(ACC_W), .CH_W(CH_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
`ifdef NCO_SYNC_EN
    .sync_in (sync_in),
`endif
    .ch_en   (ch_en),
    .wr      (wr_if),
    .clk_out (clk_out),
    .tick    (tick),
    .pending (pending)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int m_ph [NUM_CH];
  int m_act[NUM_CH];
  int m_shd[NUM_CH];
  bit m_pend[NUM_CH];
  bit m_tick[NUM_CH];
  int checks = 0;
  int errors = 0;

  task automatic model_clear();
    for (int c = 0; c < NUM_CH; c++) begin
      m_ph[c] = 0; m_act[c] = 0; m_shd[c] = 0; m_pend[c] = 0; m_tick[c] = 0;
    end
  endtask

  task automatic model_step();
    for (int c = 0; c < NUM_CH; c++) begin
      bit w;
      int v;
      int s;
      bit carry;
      w = wr_if.wr_en && (int'(wr_if.wr_ch) == c);
      v = int'(wr_if.wr_inc);
      if (!ch_en[c]) begin
        if (m_pend[c]) m_act[c] = m_shd[c];
        m_ph[c] = 0;
        m_tick[c] = 0;
        if (w) begin m_shd[c] = v; m_pend[c] = 1; end
        else m_pend[c] = 0;
      end else begin
        s = m_ph[c] + m_act[c];
        carry = (s >= MOD);
        m_ph[c] = s % MOD;
        m_tick[c] = carry;
        if (carry && w) begin m_act[c] = v; m_shd[c] = v; m_pend[c] = 0; end
        else if (w) begin m_shd[c] = v; m_pend[c] = 1; end
        else if (carry && m_pend[c]) begin m_act[c] = m_shd[c]; m_pend[c] = 0; end
      end
    end
  endtask

  always @(negedge reset_n) model_clear();
  always @(posedge clk) if (reset_n) model_step();

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [NUM_CH-1:0] e_clk, e_tick, e_pend;
    for (int c = 0; c < NUM_CH; c++) begin
      e_clk[c]  = (m_ph[c] >= HALF);
      e_tick[c] = m_tick[c];
      e_pend[c] = m_pend[c];
    end
    check("model_clk_out", 32'(clk_out), 32'(e_clk));
    check("model_tick",    32'(tick),    32'(e_tick));
    check("model_pending", 32'(pending), 32'(e_pend));
  end

  // ---------------- driver tasks (called at negedge) ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_write(input int ch, input int val);
    wr_if.wr_en  = 1'b1;
    wr_if.wr_ch  = CH_W'(ch);
    wr_if.wr_inc = ACC_W'(val);
    @(negedge clk);
    wr_if.wr_en  = 1'b0;
  endtask

  task automatic wait_tick(input int ch, input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick[ch] && n < budget);
    if (!tick[ch]) begin
      checks++;
      errors++;
      $display("FAIL wait_tick_ch%0d: no tick within %0d cycles", ch, budget);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] clk_v, tick_v;
    int n, inc1, inc2, cnt1, cnt2;

    wr_if.wr_en = 1'b0;
    wr_if.wr_ch = '0;
    wr_if.wr_inc = '0;
    #1 reset_n = 1'b0;
    cyc(3);
    check("reset_clk_out", 32'(clk_out), 32'd0);
    check("reset_tick",    32'(tick),    32'd0);
    check("reset_pending", 32'(pending), 32'd0);
    reset_n = 1'b1;
    cyc(2);

    // inc=MOD/4 -> 2 high / 2 low, tick every 4th cycle
    do_write(0, 256);
    check("wr_disabled_pending", 32'(pending), 32'b001);
    cyc(1);
    check("wr_disabled_applied", 32'(pending), 32'b000);
    ch_en[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      clk_v  = {clk_v[6:0], clk_out[0]};
      tick_v = {tick_v[6:0], tick[0]};
    end
    check("quarter_clk_pattern",  32'(clk_v),  32'(8'b01100110));
    check("quarter_tick_pattern", 32'(tick_v), 32'(8'b00010001));

    // mid-period rate change waits for the wrap
    cyc(1);
    do_write(0, 128);
    check("mid_write_pending", 32'(pending[0]), 32'd1);
    wait_tick(0, 8, n);
    check("pending_cleared_at_wrap", 32'(pending[0]), 32'd0);
    wait_tick(0, 20, n);
    check("half_rate_period", 32'(n), 32'd8);

    // write landing exactly in the carry cycle bypasses the shadow
    n = 0;
    while (m_ph[0] + m_act[0] < MOD && n < 20) begin @(negedge clk); n++; end
    do_write(0, 200);
    check("wrap_write_tick",    32'(tick[0]),    32'd1);
    check("wrap_write_pending", 32'(pending[0]), 32'd0);
    wait_tick(0, 20, n);
    check("wrap_write_new_period", 32'(n), 32'd6);

    // out-of-range channel is ignored
    do_write(NUM_CH, 77);
    check("bad_ch_pending", 32'(pending), 32'd0);

    // disable mid-count with a pending write, then restart from zero
    cyc(1);
    do_write(0, 100);
    check("pre_disable_pending", 32'(pending[0]), 32'd1);
    ch_en[0] = 1'b0;
    @(negedge clk);
    check("disable_clk_out", 32'(clk_out[0]), 32'd0);
    check("disable_tick",    32'(tick[0]),    32'd0);
    check("disable_pending", 32'(pending[0]), 32'd0);
    ch_en[0] = 1'b1;
    wait_tick(0, 30, n);
    check("reenable_first_tick", 32'(n), 32'd11);

    // frequency rule: exactly inc ticks per 2^ACC_W cycles, including aliased rates
    inc1 = $urandom_range(1, HALF - 1);
    inc2 = $urandom_range(HALF, MOD - 1);
    do_write(1, inc1);
    do_write(2, inc2);
    cyc(1);
    ch_en[2:1] = 2'b11;
    cyc(3);
    cnt1 = 0; cnt2 = 0;
    for (int i = 0; i < MOD; i++) begin
      @(negedge clk);
      cnt1 += int'(tick[1]);
      cnt2 += int'(tick[2]);
    end
    check("freq_ticks_ch1", 32'(cnt1), 32'(inc1));
    check("freq_ticks_ch2", 32'(cnt2), 32'(inc2));

    // randomized writes and enable toggling against the model
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      wr_if.wr_en  = ($urandom_range(0, 3) == 0);
      wr_if.wr_ch  = CH_W'($urandom_range(0, 3));
      wr_if.wr_inc = ($urandom_range(0, 9) == 0) ? '0 : ACC_W'($urandom_range(1, MOD - 1));
      if ($urandom_range(0, 31) == 0) ch_en[$urandom_range(0, NUM_CH - 1)] ^= 1'b1;
    end
    @(negedge clk);
    wr_if.wr_en = 1'b0;
    ch_en = '1;
    cyc(20);

    // asynchronous reset mid-operation
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_clk_out", 32'(clk_out), 32'd0);
    check("async_reset_tick",    32'(tick),    32'd0);
    check("async_reset_pending", 32'(pending), 32'd0);
    cyc(2);
    reset_n = 1'b1;
    cnt1 = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cnt1 += int'(|clk_out) + int'(|tick);
    end
    check("post_reset_idle", 32'(cnt1), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
